// File: rtl/dm_ctrl_pkg.sv
// Shared constants and state encoding for the MEM-stage data-memory / serial-port controller.
package dm_ctrl_pkg;

    localparam logic [15:0] SERIAL_DATA_DEFAULT   = 16'hBF00;
    localparam logic [15:0] SERIAL_STATUS_DEFAULT = 16'hBF01;

    typedef enum logic [3:0] {
        IDLE,
        RD_ACT,
        WR_SETUP,
        WR_ACT,
        TX_WAIT,
        TX_ACT,
        RX_WAIT,
        RX_ACT,
        DONE
    } dm_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dm_ctrl_pulse_timer.sv
// Loadable down-counter shared by every active state; done is high once the count reaches zero.
module dm_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle MEM-stage controller: drives the shared Ram1 SRAM / UART bus with registered
// strobes and wait states, and holds the pipeline until each access completes.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int                    DATA_W             = 16,
    parameter int                    ADDR_W             = 18,
    parameter int                    CPU_ADDR_W         = 16,
    parameter int                    RAM_WAIT           = 1,
    parameter int                    UART_PULSE         = 2,
    parameter int                    BLOCKING           = 1,
    parameter logic [CPU_ADDR_W-1:0] SERIAL_DATA_ADDR   = SERIAL_DATA_DEFAULT,
    parameter logic [CPU_ADDR_W-1:0] SERIAL_STATUS_ADDR = SERIAL_STATUS_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [CPU_ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0]     DataIn,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  data_ready,
    input  logic                  tbre,
    input  logic                  tsre,
    output logic [DATA_W-1:0]     DataOut,
    output logic                  Stall,
    output logic                  Ram1_EN,
    output logic                  Ram1_OE,
    output logic                  Ram1_WE,
    output logic [ADDR_W-1:0]     Ram1_address,
    inout  wire logic [DATA_W-1:0] Ram1_data,
    output logic                  rdn,
    output logic                  wrn
);

    localparam int TMR_W = $clog2(max_int(RAM_WAIT + 1, UART_PULSE) + 1);
    localparam logic [TMR_W-1:0] RAM_LOAD   = TMR_W'(RAM_WAIT);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(UART_PULSE - 1);

    dm_state_t state, next_state;

    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_load_val;
    logic                  tmr_dec;
    logic                  tmr_done;
    logic                  accept;
    logic                  status_rd;
    logic                  stall_c;
    logic                  drive;
    logic [CPU_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;

    logic tx_ready;
    logic is_status;
    logic is_serial;

    assign tx_ready  = tbre & tsre;
    assign is_status = (Addr == SERIAL_STATUS_ADDR);
    assign is_serial = (Addr == SERIAL_DATA_ADDR);

    dm_pulse_timer #(.W(TMR_W)) u_timer (
        .clk      (Clk),
        .rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status-register accesses never leave IDLE; everything else is latched and sequenced.
    always_comb begin
        next_state   = state;
        stall_c      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        accept       = 1'b0;
        status_rd    = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_status) begin
                    status_rd = MemRead && !MemWrite;
                end else if (MemWrite) begin
                    accept = 1'b1;
                    if (!is_serial) begin
                        next_state = WR_SETUP;
                    end else if ((BLOCKING != 0) && !tx_ready) begin
                        next_state = TX_WAIT;
                    end else begin
                        next_state   = TX_ACT;
                        tmr_load     = 1'b1;
                        tmr_load_val = PULSE_LOAD;
                    end
                end else if (MemRead) begin
                    accept = 1'b1;
                    if (!is_serial) begin
                        next_state   = RD_ACT;
                        tmr_load     = 1'b1;
                        tmr_load_val = RAM_LOAD;
                    end else if ((BLOCKING != 0) && !data_ready) begin
                        next_state = RX_WAIT;
                    end else begin
                        next_state   = RX_ACT;
                        tmr_load     = 1'b1;
                        tmr_load_val = PULSE_LOAD;
                    end
                end
                stall_c = accept;
            end
            WR_SETUP: begin
                stall_c      = 1'b1;
                next_state   = WR_ACT;
                tmr_load     = 1'b1;
                tmr_load_val = RAM_LOAD;
            end
            TX_WAIT: begin
                stall_c = 1'b1;
                if (tx_ready) begin
                    next_state   = TX_ACT;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LOAD;
                end
            end
            RX_WAIT: begin
                stall_c = 1'b1;
                if (data_ready) begin
                    next_state   = RX_ACT;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LOAD;
                end
            end
            RD_ACT, WR_ACT, TX_ACT, RX_ACT: begin
                stall_c = 1'b1;
                if (tmr_done) begin
                    next_state = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign Stall = stall_c && !Rst;

    // Strobes are registered from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Ram1_EN <= 1'b1;
            Ram1_OE <= 1'b1;
            Ram1_WE <= 1'b1;
            rdn     <= 1'b1;
            wrn     <= 1'b1;
            drive   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            DataOut <= '0;
        end else begin
            Ram1_EN <= !(next_state inside {RD_ACT, WR_SETUP, WR_ACT});
            Ram1_OE <= (next_state != RD_ACT);
            Ram1_WE <= (next_state != WR_ACT);
            rdn     <= (next_state != RX_ACT);
            wrn     <= (next_state != TX_ACT);
            drive   <= (next_state inside {WR_SETUP, WR_ACT, TX_ACT}) ||
                       ((next_state == DONE) && (state inside {WR_ACT, TX_ACT}));
            if (accept) begin
                addr_q <= Addr;
                data_q <= DataIn;
            end
            if (status_rd) begin
                DataOut <= {{(DATA_W-2){1'b0}}, data_ready, tx_ready};
            end else if ((state == RD_ACT) && tmr_done) begin
                DataOut <= Ram1_data;
            end else if ((state == RX_ACT) && tmr_done) begin
                DataOut <= {{(DATA_W-8){1'b0}}, Ram1_data[7:0]};
            end
        end
    end

    assign Ram1_address = {{(ADDR_W-CPU_ADDR_W){1'b0}}, addr_q};
    assign Ram1_data    = drive ? data_q : {DATA_W{1'bz}};

endmodule
